// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request, MTHI/MTLO and HI/LO result bundle for the multiply/divide unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand0;
  logic [WIDTH-1:0] operand1;
  logic             hi_wren;
  logic             lo_wren;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand0, operand1, hi_wren, lo_wren, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand0, operand1, hi_wren, lo_wren, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-cycle multiply/divide unit with HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign0_q, sign0_d;
  logic               sign1_q, sign1_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   mag1_q, mag1_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               in_signed;
  logic               in_sign0;
  logic               in_sign1;
  logic [WIDTH-1:0]   in_mag0;
  logic [WIDTH-1:0]   in_mag1;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  // Next-state, datapath step and sign-fix logic for the whole unit
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    dz_d    = dz_q;
    mag1_d  = mag1_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // MULT and DIV (op[0]==0) work on magnitudes; the unsigned forms take raw bits
    in_signed = ~bus.op[0];
    in_sign0  = in_signed & bus.operand0[WIDTH-1];
    in_sign1  = in_signed & bus.operand1[WIDTH-1];
    in_mag0   = in_sign0 ? -bus.operand0 : bus.operand0;
    in_mag1   = in_sign1 ? -bus.operand1 : bus.operand1;

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag1_q : {WIDTH{1'b0}})};

    // Divide: shift the next dividend bit into the remainder; the extra top bit gives the borrow
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {2'b00, mag1_q};

    prod = ((op_q == OP_MULT) && (sign0_q ^ sign1_q)) ? -acc_q : acc_q;
    quo  = ((op_q == OP_DIV) && (sign0_q ^ sign1_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd  = ((op_q == OP_DIV) && sign0_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    // A zero divisor leaves the dividend as remainder; only the quotient needs forcing
    if (dz_q) begin
      quo = {WIDTH{1'b1}};
    end

    case (state_q)
      IDLE: begin
        if (bus.hi_wren) begin
          hi_d = bus.wdata;
        end
        if (bus.lo_wren) begin
          lo_d = bus.wdata;
        end
        if (bus.start) begin
          op_d    = bus.op;
          sign0_d = in_sign0;
          sign1_d = in_sign1;
          dz_d    = (bus.operand1 == {WIDTH{1'b0}});
          mag1_d  = in_mag1;
          acc_d   = {{WIDTH{1'b0}}, in_mag0};
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
          rem_d = div_diff[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = rmd;
          lo_d = quo;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      dz_q    <= 1'b0;
      mag1_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      dz_q    <= dz_d;
      mag1_q  <= mag1_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  string       exp_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start cycle and record the expected HI/LO in the scoreboard
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string n);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.operand0 = a;
    bus.operand1 = b;
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    exp_name_q.push_back(n);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.operand0 = 32'hA5A5_A5A5;
    bus.operand1 = 32'h5A5A_5A5A;
    bus.op       = ~o;
  endtask

  // Wait (bounded) for done; returns at the negedge on which done is seen
  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) return;
      if (bus.busy) busy_cycles++;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done within 60 cycles required done pulse");
  endtask

  // Monitor: compare every done pulse against the scoreboard and check done lasts one cycle
  initial begin
    logic        prev_done;
    logic [31:0] eh, el;
    string       n;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_cycle", {31'b0, bus.done}, 32'd0);
      if (bus.done) begin
        if (exp_hi_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending result");
        end else begin
          eh = exp_hi_q.pop_front();
          el = exp_lo_q.pop_front();
          n  = exp_name_q.pop_front();
          check({n, "_hi"}, bus.hi, eh);
          check({n, "_lo"}, bus.lo, el);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    int bc;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand0 = '0; bus.operand1 = '0;
    bus.hi_wren = 1'b0; bus.lo_wren = 1'b0; bus.wdata = '0;

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: unsigned max product and busy length
    @(posedge clk); #1;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    wait_done(bc);
    check("busy_cycles_multu", 32'(bc), 32'd33);

    // 2: signed multiply combinations
    @(posedge clk); #1;
    issue(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
    wait_done(bc);
    @(posedge clk); #1;
    issue(MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7xm3");
    wait_done(bc);
    @(posedge clk); #1;
    issue(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0, 32'h15, "mult_m3xm7");
    wait_done(bc);

    // 3: signed/unsigned divide; the DIVU starts in the done cycle of the DIV
    @(posedge clk); #1;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    wait_done(bc);
    issue(DIVU, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, "divu_b2b");
    wait_done(bc);
    check("busy_cycles_b2b", 32'(bc), 32'd33);

    // 4: divide by zero and the wrapping signed case
    @(posedge clk); #1;
    issue(DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, "divu_by0");
    wait_done(bc);
    @(posedge clk); #1;
    issue(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0");
    wait_done(bc);
    @(posedge clk); #1;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_min_m1");
    wait_done(bc);

    // 5: start and MTHI while busy are ignored
    @(posedge clk); #1;
    issue(MULTU, 32'd3, 32'd5, 32'h0, 32'd15, "multu_busy_ign");
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = DIVU; bus.operand0 = 32'd9; bus.operand1 = 32'd3;
    bus.hi_wren = 1'b1; bus.wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_wren = 1'b0;
    @(negedge clk);
    check("busy_after_ign", {31'b0, bus.busy}, 32'd1);
    check("hi_unchanged_busy", bus.hi, 32'd0);
    wait_done(bc);

    // 6: MTHI/MTLO in IDLE, then reset mid-operation
    @(posedge clk); #1;
    bus.hi_wren = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.hi_wren = 1'b0; bus.lo_wren = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk);
    check("mthi", bus.hi, 32'h1234);
    @(posedge clk); #1;
    bus.lo_wren = 1'b0;
    @(negedge clk);
    check("mtlo", bus.lo, 32'h5678);
    check("mthi_kept", bus.hi, 32'h1234);
    @(posedge clk); #1;
    bus.hi_wren = 1'b1; bus.lo_wren = 1'b1; bus.wdata = 32'hCAFE;
    @(posedge clk); #1;
    bus.hi_wren = 1'b0; bus.lo_wren = 1'b0;
    @(negedge clk);
    check("mthi_both", bus.hi, 32'hCAFE);
    check("mtlo_both", bus.lo, 32'hCAFE);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MULTU; bus.operand0 = 32'd2; bus.operand1 = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(MULTU, 32'd2, 32'd2, 32'h0, 32'd4, "multu_rerun");
    wait_done(bc);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(exp_hi_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
